// File: rtl/fir_pkg.sv
// Shared definitions for the FIR block family: default word lengths and the
// playback state encoding used by the sample source.
package fir_pkg;

  localparam int IN_INTE_WL  = 4;
  localparam int IN_FRAC_WL  = 8;
  localparam int OUT_INTE_WL = 4;
  localparam int OUT_FRAC_WL = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } src_state_t;

endpackage

// File: rtl/fir_src_mem.sv
// Sample buffer for the FIR source: one synchronous write port and one
// asynchronous read port, no reset so contents survive a playback reset.
module fir_src_mem #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 12,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_sample_source.sv
// Plays a preloaded buffer of signed samples into a FIR input, one sample per
// PLAY cycle with an optional idle gap between samples, then pulses done.
module fir_sample_source
  import fir_pkg::src_state_t, fir_pkg::IDLE, fir_pkg::PLAY, fir_pkg::GAP, fir_pkg::DONE;
#(
  parameter int IN_INTE_WL = fir_pkg::IN_INTE_WL,
  parameter int IN_FRAC_WL = fir_pkg::IN_FRAC_WL,
  parameter int DEPTH      = 256,
  localparam int AW        = $clog2(DEPTH),
  localparam int WL        = IN_INTE_WL + IN_FRAC_WL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WL-1:0]        wr_data,
  input  logic [AW:0]          num_samples,
  input  logic [7:0]           gap_cycles,
  input  logic                 start,
  input  logic                 abort,
  output logic signed [WL-1:0] data_in,
  output logic                 in_valid,
  output logic                 busy,
  output logic                 done
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  src_state_t    state, state_nx;
  logic [AW-1:0] rd_ptr, rd_ptr_nx, rd_addr;
  logic [AW:0]   remain, remain_nx;
  logic [7:0]    gap_len, gap_len_nx;
  logic [7:0]    gap_cnt, gap_cnt_nx;
  logic [AW:0]   n_clamped;
  logic          emit;
  logic          mem_we;
  logic [WL-1:0] mem_rdata, rd_word;

  assign mem_we    = wr_en && (state == IDLE);
  assign n_clamped = (num_samples > DEPTH_W) ? DEPTH_W : num_samples;
  assign busy      = (state != IDLE);

  fir_src_mem #(
    .DEPTH(DEPTH),
    .WIDTH(WL)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(mem_rdata)
  );

  // A write landing in the same cycle as start must be seen by the first read.
  assign rd_word = (mem_we && (wr_addr == rd_addr)) ? wr_data : mem_rdata;

  // Next-state logic; emit marks a cycle whose successor presents a sample,
  // and remain counts samples still to present after the current one.
  always_comb begin
    state_nx   = state;
    rd_ptr_nx  = rd_ptr;
    rd_addr    = rd_ptr;
    remain_nx  = remain;
    gap_len_nx = gap_len;
    gap_cnt_nx = gap_cnt;
    emit       = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          gap_len_nx = gap_cycles;
          rd_addr    = '0;
          if (n_clamped == '0) begin
            state_nx = DONE;
          end else begin
            state_nx  = PLAY;
            emit      = 1'b1;
            remain_nx = n_clamped - 1'b1;
          end
        end
      end
      PLAY: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (remain == '0) begin
          state_nx = DONE;
        end else if (gap_len != 8'd0) begin
          state_nx   = GAP;
          gap_cnt_nx = gap_len - 8'd1;
        end else begin
          emit      = 1'b1;
          remain_nx = remain - 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (gap_cnt == 8'd0) begin
          state_nx  = PLAY;
          emit      = 1'b1;
          remain_nx = remain - 1'b1;
        end else begin
          gap_cnt_nx = gap_cnt - 8'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (emit) begin
      rd_ptr_nx = rd_addr + 1'b1;
    end
  end

  // Registered state and outputs; data_in is forced to zero outside valid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      remain   <= '0;
      gap_len  <= '0;
      gap_cnt  <= '0;
      in_valid <= 1'b0;
      data_in  <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_ptr   <= rd_ptr_nx;
      remain   <= remain_nx;
      gap_len  <= gap_len_nx;
      gap_cnt  <= gap_cnt_nx;
      in_valid <= emit;
      data_in  <= emit ? rd_word : '0;
      done     <= (state_nx == DONE);
    end
  end

endmodule

// File: doc/fir_sample_source.md
FIR_SAMPLE_SOURCE -- requirements
Module: fir_sample_source

Interface
REQ-001 Parameter IN_INTE_WL, default 4, integer bits of each emitted sample.
REQ-002 Parameter IN_FRAC_WL, default 8, fractional bits of each emitted sample.
REQ-003 Parameter DEPTH, default 256, sample buffer entries; power of two, AW = log2(DEPTH).
REQ-004 Port clk  input  1  single clock for all logic, rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port wr_en  input  1  buffer write strobe.
REQ-007 Port wr_addr  input  AW  buffer write address.
REQ-008 Port wr_data  input  IN_INTE_WL+IN_FRAC_WL  signed sample, format [IN_INTE_WL-1:-IN_FRAC_WL].
REQ-009 Port num_samples  input  AW+1  samples to play, sampled on accepted start.
REQ-010 Port gap_cycles  input  8  idle cycles inserted between samples, sampled on accepted start.
REQ-011 Port start  input  1  single-cycle playback request.
REQ-012 Port abort  input  1  terminate playback.
REQ-013 Port data_in  output  IN_INTE_WL+IN_FRAC_WL  signed sample driven into the FIR's data_in.
REQ-014 Port in_valid  output  1  data_in qualifier, drives the FIR's in_valid.
REQ-015 Port busy  output  1  high while not IDLE.
REQ-016 Port done  output  1  one-cycle pulse after the last sample.

Function
REQ-017 FSM states: IDLE, PLAY, GAP, DONE.
REQ-018 IDLE: start=1 -> PLAY next edge; latch n = min(num_samples, DEPTH), gap = gap_cycles; rd_ptr = 0.
REQ-019 start at cycle N -> first in_valid=1 at cycle N+1 with data_in = mem[0]; latency exactly 1.
REQ-020 PLAY: every cycle in PLAY, in_valid=1, data_in = mem[rd_ptr], rd_ptr increments.
REQ-021 PLAY with gap>0 and samples remaining -> GAP for exactly gap cycles (in_valid=0), then PLAY.
REQ-022 After the n-th sample -> DONE; DONE asserts done=1 for one cycle, then IDLE.
REQ-023 n=0 (num_samples=0) on start -> DONE directly; no in_valid cycle; done one cycle after start.
REQ-024 num_samples > DEPTH -> clamped to DEPTH; rd_ptr never wraps.
REQ-025 data_in = 0 whenever in_valid=0.
REQ-026 start while busy=1 ignored.
REQ-027 abort=1 in PLAY/GAP -> IDLE next edge, in_valid=0, no done pulse; abort in IDLE/DONE ignored; abort wins over start same cycle.
REQ-028 wr_en while busy=1 ignored (buffer stable during playback); wr_en in IDLE writes wr_data to mem[wr_addr] next edge.
REQ-029 Write and start in same IDLE cycle: write committed; playback of that address uses new data.
REQ-030 Outputs in_valid, data_in, done are registered; no combinational input-to-output path.

Reset
REQ-031 rst=1 -> state IDLE, rd_ptr 0, in_valid 0, data_in 0, busy 0, done 0, immediately (asynchronous).
REQ-032 rst mid-playback aborts with no done pulse; buffer contents not cleared.
REQ-033 First start honoured on the first edge after rst deasserts.

Structure
REQ-034 Shared package fir_pkg holds FSM state enum and default word-length constants (IN_INTE_WL, IN_FRAC_WL, OUT_INTE_WL, OUT_FRAC_WL = 4/8/4/8).
REQ-035 One sub-module fir_src_mem: DEPTH x (IN_INTE_WL+IN_FRAC_WL) single-write, asynchronous-read buffer.
REQ-036 Sample width derived from IN_INTE_WL+IN_FRAC_WL only; matches FIR data_in width for direct connection.

Verification
REQ-037 Load mem[0..3]=0x100,0xF00,0x080,0x7FF; num_samples=4, gap=0, start at cycle 10 -> in_valid cycles 11-14, data 0x100,0xF00,0x080,0x7FF; done at 15.
REQ-038 Same load, gap_cycles=2 -> valid at 11,14,17,20; in_valid=0 and data_in=0 between; done at 21.
REQ-039 num_samples=0, start -> no in_valid, done one cycle after start, busy high one cycle.
REQ-040 num_samples=4, abort at second sample -> in_valid low next cycle, no done, busy low; new start replays from mem[0].
REQ-041 rst asserted mid-PLAY -> outputs 0 without clock edge; buffer retains 0x100 at mem[0] on replay.
REQ-042 Drive fir_sample_source into FIR with impulse (0x100 then 15 zeros) -> FIR output sequence equals coefficient set.
